rv_alu_reg: RTL and testbench

- RV32I integer ALU for the execute stage, with registered outputs.
- Computes AND, OR, ADD and SUB on two XLEN-bit operands, plus a zero flag for branch decisions.
- An optional extension adds XOR, shifts and set-less-than operations.
- Opcode encoding follows alu_op_t in riscv_32i_defs_pkg (4-bit field).

---
 rtl/rv_alu_reg.sv | 77 +++++++
 tb/tb_rv_alu_reg.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rv_alu_reg.sv
// rtl/rv_alu_reg.sv - RV32I execute-stage ALU with a single registered output stage.
// Optional macro ALU_FULL_OPS_EN adds XOR, SLL, SRL, SRA, SLT and SLTU.
module rv_alu_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal_op
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
`ifdef ALU_FULL_OPS_EN
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  logic [4:0] shamt;
  assign shamt = in_b[4:0];
`endif

  logic [XLEN-1:0] next_result;
  logic            next_illegal;

  always_comb begin
    next_result  = '0;
    next_illegal = 1'b0;
    case (alu_op)
      ALU_AND:  next_result = in_a & in_b;
      ALU_OR:   next_result = in_a | in_b;
      ALU_ADD:  next_result = in_a + in_b;
      ALU_SUB:  next_result = in_a - in_b;
`ifdef ALU_FULL_OPS_EN
      ALU_XOR:  next_result = in_a ^ in_b;
      ALU_SLL:  next_result = in_a << shamt;
      ALU_SRL:  next_result = in_a >> shamt;
      ALU_SRA:  next_result = $unsigned($signed(in_a) >>> shamt);
      ALU_SLT:  next_result = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      ALU_SLTU: next_result = {{(XLEN-1){1'b0}}, (in_a < in_b)};
`endif
      default: begin
        next_result  = '0;
        next_illegal = 1'b1;
      end
    endcase
  end

  // Idle cycles only drop out_valid; the last result stays visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      result     <= '0;
      illegal_op <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result     <= next_result;
        illegal_op <= next_illegal;
      end
    end
  end

  assign zero = (result == '0);

endmodule

// File: tb/tb_rv_alu_reg.sv
// tb/tb_rv_alu_reg.sv - Directed table, corner sequences and random regression for rv_alu_reg.
module tb_rv_alu_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  alu_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        illegal_op;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv_alu_reg #(.XLEN(32)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .alu_op(alu_op),
    .in_a(in_a),
    .in_b(in_b),
    .out_valid(out_valid),
    .result(result),
    .zero(zero),
    .illegal_op(illegal_op)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_zero;
    logic        exp_ill;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then sample just after the rising edge.
  task automatic cycle(input logic r, input logic v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    rst = r; in_valid = v; alu_op = op; in_a = a; in_b = b;
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill);
    logic [4:0] sh;
    sh  = b[4:0];
    r   = 32'h0;
    ill = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
`ifdef ALU_FULL_OPS_EN
      4'b0011: r = a ^ b;
      4'b0100: r = a << sh;
      4'b0101: r = a >> sh;
      4'b0111: r = $unsigned($signed(a) >>> sh);
      4'b1000: r = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
      4'b1001: r = (a < b) ? 32'h1 : 32'h0;
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  initial begin
    logic [31:0] m_res;
    logic        m_ill;
    logic [31:0] held;
    logic        held_ill;
    logic        v;
    logic [3:0]  op;
    logic [31:0] a, b;

    vecs[0] = '{4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1'b0};
    vecs[1] = '{4'b0001, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF, 1'b0, 1'b0};
    vecs[2] = '{4'b0000, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 1'b1, 1'b0};
    vecs[3] = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
    vecs[4] = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0};
    vecs[5] = '{4'b0110, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0};
    vecs[6] = '{4'b0110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[7] = '{4'b1010, 32'h0BAD_F00D, 32'h1357_9BDF, 32'h0000_0000, 1'b1, 1'b1};
    vecs[8] = '{4'b1111, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; alu_op = 4'h0; in_a = 32'h0; in_b = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset result", result, 32'h0);
    chk("reset zero", {31'b0, zero}, 32'h1);
    chk("reset illegal_op", {31'b0, illegal_op}, 32'h0);

    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, 32'h1);
      chk($sformatf("vec%0d result", i), result, vecs[i].exp_res);
      chk($sformatf("vec%0d zero", i), {31'b0, zero}, {31'b0, vecs[i].exp_zero});
      chk($sformatf("vec%0d illegal_op", i), {31'b0, illegal_op}, {31'b0, vecs[i].exp_ill});
    end

    // Reset wins over a simultaneous valid and clears the sticky illegal flag.
    cycle(1'b1, 1'b1, 4'b0010, 32'h5, 32'h3);
    chk("rst prio out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst prio result", result, 32'h0);
    chk("rst prio zero", {31'b0, zero}, 32'h1);
    chk("rst prio illegal_op", {31'b0, illegal_op}, 32'h0);
    cycle(1'b0, 1'b1, 4'b0010, 32'h5, 32'h3);
    chk("post rst out_valid", {31'b0, out_valid}, 32'h1);
    chk("post rst result", result, 32'h8);

    // Back-to-back ADD then SUB, then one idle cycle.
    cycle(1'b0, 1'b1, 4'b0010, 32'h0000_1000, 32'h0000_0234);
    chk("pipe add valid", {31'b0, out_valid}, 32'h1);
    chk("pipe add result", result, 32'h0000_1234);
    cycle(1'b0, 1'b1, 4'b0110, 32'h0000_1000, 32'h0000_0001);
    chk("pipe sub valid", {31'b0, out_valid}, 32'h1);
    chk("pipe sub result", result, 32'h0000_0FFF);
    cycle(1'b0, 1'b0, 4'b0010, 32'hFFFF_FFFF, 32'h1);
    chk("idle out_valid", {31'b0, out_valid}, 32'h0);
    chk("idle result hold", result, 32'h0000_0FFF);
    chk("idle zero hold", {31'b0, zero}, 32'h0);

    held     = result;
    held_ill = illegal_op;
    for (int i = 0; i < 5000; i++) begin
      v  = ($urandom_range(0, 7) != 0);
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = (($urandom_range(0, 7) == 0)) ? a : $urandom;
      cycle(1'b0, v, op, a, b);
      if (v) begin
        model(op, a, b, m_res, m_ill);
        held     = m_res;
        held_ill = m_ill;
      end
      chk($sformatf("rnd%0d op%0h", i, op),
          {out_valid, illegal_op, zero, result[28:0]},
          {v, held_ill, (held == 32'h0), held[28:0]});
      if (result[31:29] !== held[31:29]) begin
        n_checks++;
        n_fail++;
        $display("FAIL rnd%0d result: got %h expected %h", i, result, held);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
